// File: rtl/sd_reg_cpu_bridge.sv
// CPU-to-register-bank access bridge for the SD host register block.
// Registered address decode, one-cycle byte-enabled write strobes, registered reads.
module sd_reg_cpu_bridge #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int NUM_REGS = 12,
  parameter logic [NUM_REGS*ADDR_W-1:0] REG_ADDRS = {12'h054, 12'h032, 12'h030, 12'h02A,
                                                     12'h024, 12'h012, 12'h010, 12'h00E,
                                                     12'h00A, 12'h008, 12'h006, 12'h004},
  parameter logic [NUM_REGS-1:0] WR_MASK = 12'hD7F
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cpu_req,
  input  logic                       cpu_wr,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic [DATA_W/8-1:0]        cpu_be,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_ack,
  output logic                       cpu_err,
  output logic [NUM_REGS-1:0]        reg_wr_en,
  output logic [DATA_W-1:0]          reg_wdata,
  output logic [DATA_W/8-1:0]        reg_be,
  input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
  output logic [7:0]                 err_cnt,
  output logic [1:0]                 dbg_state_o
);

  // Handshake: cpu_req rises and is held until cpu_ack; cpu_ack stays high
  // while cpu_req is held and falls the cycle after cpu_req drops.
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t             state_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [BE_W-1:0]    be_q;
  logic               err_q;
  logic [IDX_W-1:0]   idx_q;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               writable;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (addr_q == REG_ADDRS[i*ADDR_W +: ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    writable = WR_MASK[hit_idx];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      reg_wr_en <= '0;
      reg_wdata <= '0;
      reg_be    <= '0;
      err_cnt   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            wr_q    <= cpu_wr;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            be_q    <= cpu_be;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!cpu_req) begin
            state_q <= S_IDLE;
          end else begin
            idx_q <= hit_idx;
            err_q <= !hit || (wr_q && !writable);
            // Strobe is registered here so it is visible for the whole ACCESS cycle.
            if (wr_q && hit && writable) begin
              reg_wr_en <= NUM_REGS'(1) << hit_idx;
              reg_wdata <= wdata_q;
              reg_be    <= be_q;
            end
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          reg_wr_en <= '0;
          reg_wdata <= '0;
          reg_be    <= '0;
          cpu_rdata <= (!wr_q && !err_q) ? reg_rdata[idx_q*DATA_W +: DATA_W] : '0;
          cpu_ack   <= 1'b1;
          cpu_err   <= err_q;
          if (err_q && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
          end
          state_q <= S_ACK;
        end
        S_ACK: begin
          if (!cpu_req) begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbg_state_o = state_q;

endmodule
